// File: rtl/eth_wrr_sched.sv
// Weighted round-robin frame scheduler: up to weight[n] frames per round, grant held until tlast ack.
// Optional per-source frame counters are built when ETH_WRR_STATS_EN is defined.
module eth_wrr_sched #(
   parameter int unsigned S_COUNT      = 4,
   parameter int unsigned WEIGHT_WIDTH = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [S_COUNT-1:0]                request,
   input  logic [S_COUNT-1:0]                acknowledge,
   input  logic [S_COUNT*WEIGHT_WIDTH-1:0]   weight_cfg,
   input  logic                              weight_load,
   output logic [S_COUNT-1:0]                grant,
   output logic                              grant_valid,
   output logic [$clog2(S_COUNT)-1:0]        grant_encoded,
   output logic [S_COUNT*16-1:0]             frame_count,
   input  logic                              stat_clear
);

   localparam int unsigned IW = $clog2(S_COUNT);
   localparam int unsigned WW = WEIGHT_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_REFILL} state_e;

   state_e          state_q;
   logic [IW-1:0]   ptr_q;
   logic [WW-1:0]   weight_q [S_COUNT];
   logic [WW-1:0]   credit_q [S_COUNT];

   logic [S_COUNT-1:0] eligible_c;
   logic               sel_found_c;
   logic [IW-1:0]      sel_idx_c;
   logic               refill_req_c;
   logic               ack_c;
   logic [WW-1:0]      credit_dec_c;
   logic [IW-1:0]      ptr_inc_c;

   // First eligible source at or after the pointer; descending scan so the nearest one wins.
   always_comb begin
      int idx;
      eligible_c   = '0;
      sel_found_c  = 1'b0;
      sel_idx_c    = '0;
      refill_req_c = 1'b0;
      idx          = 0;
      for (int i = 0; i < int'(S_COUNT); i++) begin
         eligible_c[i] = request[i] && (credit_q[i] != '0) && (weight_q[i] != '0);
         if (request[i] && (weight_q[i] != '0)) refill_req_c = 1'b1;
      end
      for (int k = int'(S_COUNT) - 1; k >= 0; k--) begin
         idx = int'(ptr_q) + k;
         if (idx >= int'(S_COUNT)) idx = idx - int'(S_COUNT);
         if (eligible_c[idx]) begin
            sel_found_c = 1'b1;
            sel_idx_c   = IW'(idx);
         end
      end
   end

   always_comb begin
      ack_c        = grant_valid && acknowledge[grant_encoded];
      credit_dec_c = (credit_q[grant_encoded] == '0) ? '0 : credit_q[grant_encoded] - WW'(1);
      ptr_inc_c    = (grant_encoded == IW'(S_COUNT - 1)) ? '0 : grant_encoded + IW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         ptr_q         <= '0;
         grant         <= '0;
         grant_valid   <= 1'b0;
         grant_encoded <= '0;
         for (int n = 0; n < int'(S_COUNT); n++) begin
            weight_q[n] <= WW'(1);
            credit_q[n] <= WW'(1);
         end
      end else begin
         if (weight_load) begin
            for (int n = 0; n < int'(S_COUNT); n++) weight_q[n] <= weight_cfg[n*WW +: WW];
         end
         case (state_q)
            S_IDLE: begin
               if (sel_found_c) begin
                  grant         <= S_COUNT'(1) << sel_idx_c;
                  grant_encoded <= sel_idx_c;
                  grant_valid   <= 1'b1;
                  state_q       <= S_GRANT;
               end else if (refill_req_c) begin
                  state_q <= S_REFILL;
               end
            end
            S_REFILL: begin
               // A weight strobe landing on the refill cycle takes effect immediately.
               for (int n = 0; n < int'(S_COUNT); n++)
                  credit_q[n] <= weight_load ? weight_cfg[n*WW +: WW] : weight_q[n];
               state_q <= S_IDLE;
            end
            S_GRANT: begin
               if (ack_c) begin
                  credit_q[grant_encoded] <= credit_dec_c;
                  ptr_q                   <= (credit_dec_c == '0) ? ptr_inc_c : grant_encoded;
                  grant                   <= '0;
                  grant_valid             <= 1'b0;
                  state_q                 <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef ETH_WRR_STATS_EN
   logic [15:0] cnt_q [S_COUNT];

   // Clear wins over a coincident ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < int'(S_COUNT); n++) cnt_q[n] <= '0;
      end else begin
         for (int n = 0; n < int'(S_COUNT); n++) begin
            if (stat_clear)
               cnt_q[n] <= '0;
            else if (state_q == S_GRANT && ack_c && grant_encoded == IW'(n))
               cnt_q[n] <= cnt_q[n] + 16'd1;
         end
      end
   end

   always_comb begin
      frame_count = '0;
      for (int n = 0; n < int'(S_COUNT); n++) frame_count[n*16 +: 16] = cnt_q[n];
   end
`else
   logic unused_stat_clear;
   assign unused_stat_clear = stat_clear;
   assign frame_count       = '0;
`endif

endmodule

// File: tb/tb_eth_wrr_sched.sv
// Bench for eth_wrr_sched: directed vector table, hand-written corner sequences,
// and a randomized run against a high-level scheduling model.
module tb_eth_wrr_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  request;
   logic [3:0]  acknowledge;
   logic [15:0] weight_cfg;
   logic        weight_load;
   logic [3:0]  grant;
   logic        grant_valid;
   logic [1:0]  grant_encoded;
   logic [63:0] frame_count;
   logic        stat_clear;

   int n_total = 0;
   int n_pass  = 0;

   eth_wrr_sched #(.S_COUNT(4), .WEIGHT_WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
      .weight_cfg(weight_cfg), .weight_load(weight_load), .grant(grant),
      .grant_valid(grant_valid), .grant_encoded(grant_encoded),
      .frame_count(frame_count), .stat_clear(stat_clear)
   );

   always #5 clk = ~clk;

   // Scheduling model: abstract per-source weights/credits, a turn pointer and the granted source.
   int m_w[4], m_c[4], m_cnt[4];
   int m_ptr, m_g;
   bit m_refill;

   task automatic model_reset();
      for (int n = 0; n < 4; n++) begin m_w[n] = 1; m_c[n] = 1; m_cnt[n] = 0; end
      m_ptr = 0; m_g = -1; m_refill = 0;
   endtask

   task automatic model_step(input logic [3:0] req, input logic [3:0] ack,
                             input logic [15:0] cfg, input logic wl, input logic sc);
      int nw[4];
      int found;
      bit want;
      for (int n = 0; n < 4; n++) nw[n] = int'(cfg[n*4 +: 4]);
      if (m_refill) begin
         for (int n = 0; n < 4; n++) m_c[n] = wl ? nw[n] : m_w[n];
         m_refill = 0;
      end else if (m_g >= 0) begin
         if (ack[m_g]) begin
            if (m_c[m_g] > 0) m_c[m_g] = m_c[m_g] - 1;
            m_cnt[m_g] = (m_cnt[m_g] + 1) % 65536;
            m_ptr = (m_c[m_g] == 0) ? (m_g + 1) % 4 : m_g;
            m_g = -1;
         end
      end else begin
         found = -1;
         want  = 0;
         for (int k = 0; k < 4; k++) begin
            int n;
            n = (m_ptr + k) % 4;
            if (found < 0 && req[n] && m_c[n] > 0 && m_w[n] > 0) found = n;
            if (req[n] && m_w[n] > 0) want = 1;
         end
         if (found >= 0) m_g = found;
         else if (want) m_refill = 1;
      end
`ifdef ETH_WRR_STATS_EN
      if (sc) for (int n = 0; n < 4; n++) m_cnt[n] = 0;
`endif
      if (wl) for (int n = 0; n < 4; n++) m_w[n] = nw[n];
   endtask

   function automatic logic [63:0] model_counts();
      logic [63:0] v;
      v = '0;
`ifdef ETH_WRR_STATS_EN
      for (int n = 0; n < 4; n++) v[n*16 +: 16] = 16'(m_cnt[n]);
`endif
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; request = '0; acknowledge = '0; weight_cfg = '0;
      weight_load = 1'b0; stat_clear = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
   endtask

   // Wait (bounded) for a grant, record it, acknowledge it on the next edge.
   task automatic grant_and_ack(output int idx, output int waits);
      waits = 0;
      while (!grant_valid && waits < 20) begin step(); waits++; end
      chk("grant_arrives", 64'(grant_valid), 64'd1);
      idx = int'(grant_encoded);
      chk("grant_onehot", 64'(grant), 64'(4'b0001 << grant_encoded));
      acknowledge = 4'b0001 << grant_encoded;
      step();
      acknowledge = '0;
      chk("grant_drops_after_ack", 64'(grant_valid), 64'd0);
   endtask

   typedef struct {
      logic [3:0] req;
      logic [3:0] ack;
      logic       exp_valid;
      logic [3:0] exp_grant;
      logic [1:0] exp_enc;
   } vec_t;

   initial begin
      vec_t vt[12];
      int   idx, waits;
      int   exp_order[9];
      int   exp_waits[4];

      do_reset();
      chk("reset_grant", 64'(grant), 64'd0);
      chk("reset_valid", 64'(grant_valid), 64'd0);
      chk("reset_enc", 64'(grant_encoded), 64'd0);
      chk("reset_count", frame_count, 64'd0);

      // Default weights: one frame each, refill bubble every four frames.
      vt[0]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 2'd0};
      vt[1]  = '{4'b1111, 4'b0010, 1'b1, 4'b0001, 2'd0};
      vt[2]  = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 2'd0};
      vt[3]  = '{4'b1111, 4'b0000, 1'b1, 4'b0010, 2'd1};
      vt[4]  = '{4'b1111, 4'b0010, 1'b0, 4'b0000, 2'd0};
      vt[5]  = '{4'b1111, 4'b0000, 1'b1, 4'b0100, 2'd2};
      vt[6]  = '{4'b1111, 4'b0100, 1'b0, 4'b0000, 2'd0};
      vt[7]  = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 2'd3};
      vt[8]  = '{4'b1111, 4'b1000, 1'b0, 4'b0000, 2'd0};
      vt[9]  = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 2'd0};
      vt[10] = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 2'd0};
      vt[11] = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 2'd0};
      for (int i = 0; i < 12; i++) begin
         request = vt[i].req; acknowledge = vt[i].ack;
         step();
         chk($sformatf("vec%0d_valid", i), 64'(grant_valid), 64'(vt[i].exp_valid));
         chk($sformatf("vec%0d_grant", i), 64'(grant), 64'(vt[i].exp_grant));
         if (vt[i].exp_valid) chk($sformatf("vec%0d_enc", i), 64'(grant_encoded), 64'(vt[i].exp_enc));
      end
      acknowledge = '0;

      // Weights {3,1,0,2} (port3..0): first round still on reset credits, then weighted rounds.
      do_reset();
      weight_cfg = {4'd3, 4'd1, 4'd0, 4'd2}; weight_load = 1'b1;
      step();
      weight_load = 1'b0; request = 4'b1111;
      exp_order = '{0, 2, 3, 0, 0, 2, 3, 3, 3};
      for (int i = 0; i < 9; i++) begin
         grant_and_ack(idx, waits);
         chk($sformatf("wrr_order%0d", i), 64'(idx), 64'(exp_order[i]));
      end

      // Granted source is deaf to request drop and foreign acks.
      do_reset();
      request = 4'b0100;
      step();
      chk("hold_initial", 64'(grant), 64'b0100);
      request = 4'b0000; acknowledge = 4'b0001;
      step();
      chk("hold_valid", 64'(grant_valid), 64'd1);
      chk("hold_enc", 64'(grant_encoded), 64'd2);
      acknowledge = 4'b0100;
      step();
      acknowledge = '0;
      chk("hold_release", 64'(grant_valid), 64'd0);

      // Single requester with weight 2: refill bubbles appear when its credit runs out.
      do_reset();
      weight_cfg = {4'd1, 4'd1, 4'd2, 4'd1}; weight_load = 1'b1;
      step();
      weight_load = 1'b0; request = 4'b0010;
      exp_waits = '{1, 3, 1, 3};
      for (int i = 0; i < 4; i++) begin
         grant_and_ack(idx, waits);
         chk($sformatf("solo_idx%0d", i), 64'(idx), 64'd1);
         chk($sformatf("solo_wait%0d", i), 64'(waits), 64'(exp_waits[i]));
      end

      // Asynchronous reset in the middle of a grant.
      do_reset();
      request = 4'b1111;
      step();
      chk("pre_reset_grant", 64'(grant), 64'b0001);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_grant", 64'(grant), 64'd0);
      chk("async_reset_valid", 64'(grant_valid), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1; request = 4'b0100;
      step();
      chk("post_reset_grant", 64'(grant), 64'b0100);
      chk("post_reset_enc", 64'(grant_encoded), 64'd2);

      // Frame counters: five acks on port3, then clear coincident with an ack.
      do_reset();
      request = 4'b1000;
      for (int i = 0; i < 5; i++) grant_and_ack(idx, waits);
`ifdef ETH_WRR_STATS_EN
      chk("count_port3", 64'(frame_count[63:48]), 64'd5);
`else
      chk("count_port3", 64'(frame_count[63:48]), 64'd0);
`endif
      waits = 0;
      while (!grant_valid && waits < 20) begin step(); waits++; end
      chk("clear_grant", 64'(grant_valid), 64'd1);
      acknowledge = 4'b1000; stat_clear = 1'b1;
      step();
      acknowledge = '0; stat_clear = 1'b0;
      chk("count_cleared", frame_count, 64'd0);

      // Randomized traffic against the model.
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic [3:0] exp_g;
         request     = 4'($urandom) | 4'($urandom);
         acknowledge = 4'($urandom) & 4'($urandom);
         weight_load = ($urandom_range(0, 19) == 0);
         weight_cfg  = weight_load ? 16'($urandom) : weight_cfg;
         stat_clear  = ($urandom_range(0, 39) == 0);
         model_step(request, acknowledge, weight_cfg, weight_load, stat_clear);
         step();
         exp_g = (m_g >= 0) ? (4'b0001 << m_g) : 4'b0000;
         if (grant !== exp_g || grant_valid !== (m_g >= 0) ||
             (m_g >= 0 && int'(grant_encoded) != m_g) || frame_count !== model_counts()) begin
            n_total++;
            $display("FAIL rand_cyc%0d: got grant=%b valid=%b enc=%0d cnt=%h expected grant=%b valid=%0d enc=%0d cnt=%h",
                     cyc, grant, grant_valid, grant_encoded, frame_count,
                     exp_g, (m_g >= 0), m_g, model_counts());
         end else begin
            n_total++;
            n_pass++;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
